rob: RTL and testbench
======================

Name: rob

Overview:
- Reorder buffer sitting directly downstream of the front-end RAT (f_rat).
- Allocates up to ISSUE_WIDTH_MAX entries per cycle at rename/issue and supplies rob_is_ptr and rob_full to the RAT.
- Captures completion results from the CDB and retires up to ROB_MAX_RETIRE entries per cycle, in order.
- Drives the retire bus and the mispredict flush (branch_clear_id, mispredict_tag_id) that the RAT consumes.

Parameters:
ROB_SIZE, 32, number of entries (power of two)
ROB_SIZE_CLOG, 5, log2(ROB_SIZE)
ISSUE_WIDTH_MAX, 2, allocation slots per cycle
ROB_MAX_RETIRE, 2, retire slots per cycle
NUM_CDB, 2, completion write ports
SRC_LEN, 5, architectural register index width
XLEN, 32, result data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
instr_val_is  in  ISSUE_WIDTH_MAX  allocation request per slot (already masked by rob_full upstream)
rd_is  in  ISSUE_WIDTH_MAX x SRC_LEN  destination register per slot
rd_we_is  in  ISSUE_WIDTH_MAX  slot writes rd
branch_is  in  ISSUE_WIDTH_MAX  slot is a conditional branch
rob_is_ptr  out  ROB_SIZE_CLOG  tail index; the first valid slot receives this id
rob_full  out  1  fewer than ISSUE_WIDTH_MAX free entries
cdb_val  in  NUM_CDB  completion valid
cdb_robid  in  NUM_CDB x ROB_SIZE_CLOG  completing entry
cdb_data  in  NUM_CDB x XLEN  result
cdb_mispredict  in  NUM_CDB  branch resolved mispredicted
val_ret  out  ROB_MAX_RETIRE  retire slot valid
rd_ret  out  ROB_MAX_RETIRE x SRC_LEN  retiring rd (0 if no rd write)
data_ret  out  ROB_MAX_RETIRE x XLEN  retiring result
branch_ret  out  ROB_MAX_RETIRE  retiring entry is a branch
branch_clear_id  out  1  one-cycle flush pulse
mispredict_tag_id  out  ROB_SIZE_CLOG  robid of the mispredicted branch

Behaviour:
- Reset (rst=0, async):
  - head=tail=0 (ROB_SIZE_CLOG+1 bits each, MSB is the wrap bit).
  - All entry valid/done bits = 0.
  - All outputs = 0.
- Entry contents: valid, done, mispredict, branch, rd_we, rd, data.
- Occupancy:
  - count = tail - head.
  - Full when the pointer MSBs differ and the low bits are equal.
  - rob_full = (count > ROB_SIZE - ISSUE_WIDTH_MAX).
  - rob_full and rob_is_ptr are combinational from registers only, with no input dependence.
- Allocation (cycle N):
  - Valid slots are compacted: the k-th valid slot (in slot order) takes entry tail+k.
  - Examples: 2'b10 puts slot1 at tail; 2'b11 puts slot0 at tail and slot1 at tail+1.
  - tail advances by popcount(instr_val_is) at N+1.
  - Pointers wrap modulo ROB_SIZE, with the wrap bit toggling.
  - A request while rob_full is high is a protocol error. RTL must assert on it and ignore it.
- Completion:
  - Each valid CDB port sets done=1 and writes data and mispredict into its entry at the next edge.
  - A write to an invalid entry is ignored.
  - Two ports writing the same robid is illegal.
  - A completion landing in the same cycle that the entry retires cannot occur, because retire requires done=1.
- Retire (registered, one cycle):
  - Slot0 retires if the head entry is valid and done.
  - Slot r retires only if slot r-1 retires, entry head+r is valid and done, and slot r-1 is not a mispredicted branch.
  - Retire outputs appear at N+1; head advances by the retire count.
  - rd_ret = rd when rd_we=1, otherwise 0.
  - Entries that do not retire leave all retire outputs for that slot at 0.
- Mispredict flush:
  - Trigger: a retiring entry with mispredict=1, retired at cycle N.
  - At N+1: branch_clear_id=1 for exactly one cycle, and mispredict_tag_id = that robid.
  - At N+1: every entry is invalidated and tail = head = robid+1.
  - Younger entries in the same retire group do not retire.
  - Allocations presented in cycle N are dropped, and tail is not advanced by them.
- Simultaneous allocate and retire: both apply in the same cycle. count updates by +alloc-retire.
- Reset asserted mid-operation: all state is cleared immediately, and in-flight results are lost.
- Empty: head==tail with matching MSBs. Retire outputs stay 0.

Decomposition:
- Shared package (alongside rtl_constants) holds:
  - rob_entry_t struct;
  - ROB_SIZE, ROB_SIZE_CLOG, ROB_MAX_RETIRE, NUM_CDB;
  - the retire-bus struct shared with f_rat.
- Sub-module rob_retire_sel: combinational. Takes the ROB_MAX_RETIRE entries starting at head and produces the retire mask, the flush request and the flush robid.

Test Plan:
- Reset, then alloc 2'b11 twice with rd=3,4,5,6 -> rob_is_ptr 0, then 2, then 4; count=4; rob_full=0.
- Complete robid 1 then robid 0 -> no retire until robid 0 is done; the next cycle val_ret=2'b11, rd_ret={4,3}; head=2.
- Fill to 31 entries -> rob_full=1. Retire 2 -> rob_full=0. Allocate past entry 31 -> tail wraps to 0 with MSB toggled.
- Branch at robid 5 completes with cdb_mispredict=1 while robid 6 is done -> retire of 5 alone; next cycle branch_clear_id=1, mispredict_tag_id=5; ROB empty with head=tail=6.
- Alloc 2'b10 with rd=7 -> slot1 takes rob_is_ptr; CDB write to a never-allocated robid -> no state change.
- Assert rst low mid-cycle with 10 entries live -> outputs and pointers go to 0 immediately; val_ret stays 0 afterwards.

Source files
------------

// File: rtl/rob_pkg.sv
// Reorder buffer shared types: sizing, entry storage and retire bus.
package rob_pkg;
    localparam int ROB_SIZE        = 32;
    localparam int ROB_SIZE_CLOG   = 5;
    localparam int ISSUE_WIDTH_MAX = 2;
    localparam int ROB_MAX_RETIRE  = 2;
    localparam int NUM_CDB         = 2;
    localparam int SRC_LEN         = 5;
    localparam int XLEN            = 32;

    typedef logic [ROB_SIZE_CLOG-1:0] rob_id_t;
    typedef logic [ROB_SIZE_CLOG:0]   rob_ptr_t;

    typedef struct packed {
        logic               valid;
        logic               done;
        logic               mispredict;
        logic               branch;
        logic               rd_we;
        logic [SRC_LEN-1:0] rd;
        logic [XLEN-1:0]    data;
    } rob_entry_t;

    typedef struct packed {
        logic               val;
        logic [SRC_LEN-1:0] rd;
        logic [XLEN-1:0]    data;
        logic               branch;
    } rob_ret_t;
endpackage

// File: rtl/rob_retire_sel.sv
// In-order retire window: picks the leading run of done entries at head,
// stopping after the first mispredicted one.
module rob_retire_sel
    import rob_pkg::*;
(
    input  logic [ROB_MAX_RETIRE-1:0] vld,
    input  logic [ROB_MAX_RETIRE-1:0] done,
    input  logic [ROB_MAX_RETIRE-1:0] mis,
    input  rob_id_t                   head_idx,
    output logic [ROB_MAX_RETIRE-1:0] ret_mask,
    output logic                      flush,
    output rob_id_t                   flush_id
);
    logic go;

    always_comb begin
        ret_mask = '0;
        flush    = 1'b0;
        flush_id = '0;
        go       = 1'b1;
        for (int r = 0; r < ROB_MAX_RETIRE; r++) begin
            if (go && vld[r] && done[r]) begin
                ret_mask[r] = 1'b1;
                if (mis[r]) begin
                    flush    = 1'b1;
                    flush_id = head_idx + rob_id_t'(r);
                    go       = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
    end
endmodule

// File: rtl/rob.sv
// Reorder buffer: compacted multi-slot allocation, CDB completion,
// in-order multi-slot retire and mispredict flush.
module rob
    import rob_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ISSUE_WIDTH_MAX-1:0]             instr_val_is,
    input  logic [ISSUE_WIDTH_MAX-1:0][SRC_LEN-1:0] rd_is,
    input  logic [ISSUE_WIDTH_MAX-1:0]             rd_we_is,
    input  logic [ISSUE_WIDTH_MAX-1:0]             branch_is,
    output logic [ROB_SIZE_CLOG-1:0]               rob_is_ptr,
    output logic                                   rob_full,
    input  logic [NUM_CDB-1:0]                     cdb_val,
    input  logic [NUM_CDB-1:0][ROB_SIZE_CLOG-1:0]  cdb_robid,
    input  logic [NUM_CDB-1:0][XLEN-1:0]           cdb_data,
    input  logic [NUM_CDB-1:0]                     cdb_mispredict,
    output logic [ROB_MAX_RETIRE-1:0]              val_ret,
    output logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0] rd_ret,
    output logic [ROB_MAX_RETIRE-1:0][XLEN-1:0]    data_ret,
    output logic [ROB_MAX_RETIRE-1:0]              branch_ret,
    output logic                                   branch_clear_id,
    output logic [ROB_SIZE_CLOG-1:0]               mispredict_tag_id
);
    rob_entry_t ent_q [ROB_SIZE];
    rob_ret_t   ret_q [ROB_MAX_RETIRE];
    rob_ptr_t   head_q, tail_q, count;
    logic       clear_q;
    rob_id_t    tag_q;

    rob_entry_t                sel_ent [ROB_MAX_RETIRE];
    logic [ROB_MAX_RETIRE-1:0] sel_vld, sel_done, sel_mis, ret_mask;
    logic                      flush, alloc_ok;
    rob_id_t                   flush_id, head_idx;
    rob_ptr_t                  ret_cnt, alloc_cnt;
    rob_id_t                   alloc_idx [ISSUE_WIDTH_MAX];

    assign head_idx   = head_q[ROB_SIZE_CLOG-1:0];
    assign count      = tail_q - head_q;
    assign rob_full   = count > rob_ptr_t'(ROB_SIZE - ISSUE_WIDTH_MAX);
    assign rob_is_ptr = tail_q[ROB_SIZE_CLOG-1:0];
    assign alloc_ok   = !rob_full && !flush;

    always_comb begin
        ret_cnt = '0;
        for (int r = 0; r < ROB_MAX_RETIRE; r++) begin
            sel_ent[r]  = ent_q[head_idx + rob_id_t'(r)];
            sel_vld[r]  = sel_ent[r].valid;
            sel_done[r] = sel_ent[r].done;
            sel_mis[r]  = sel_ent[r].mispredict;
            ret_cnt     = ret_cnt + rob_ptr_t'(ret_mask[r]);
        end
        // k-th valid slot lands at tail+k
        alloc_cnt = '0;
        for (int s = 0; s < ISSUE_WIDTH_MAX; s++) begin
            alloc_idx[s] = rob_is_ptr + alloc_cnt[ROB_SIZE_CLOG-1:0];
            alloc_cnt    = alloc_cnt + rob_ptr_t'(instr_val_is[s]);
        end
    end

    rob_retire_sel u_sel (
        .vld      (sel_vld),
        .done     (sel_done),
        .mis      (sel_mis),
        .head_idx (head_idx),
        .ret_mask (ret_mask),
        .flush    (flush),
        .flush_id (flush_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            clear_q <= 1'b0;
            tag_q   <= '0;
            for (int i = 0; i < ROB_SIZE; i++) ent_q[i] <= '0;
            for (int r = 0; r < ROB_MAX_RETIRE; r++) ret_q[r] <= '0;
        end else begin
            for (int r = 0; r < ROB_MAX_RETIRE; r++) begin
                ret_q[r].val    <= ret_mask[r];
                ret_q[r].rd     <= (ret_mask[r] && sel_ent[r].rd_we) ?
                                   sel_ent[r].rd : '0;
                ret_q[r].data   <= ret_mask[r] ? sel_ent[r].data : '0;
                ret_q[r].branch <= ret_mask[r] && sel_ent[r].branch;
                if (ret_mask[r]) begin
                    ent_q[head_idx + rob_id_t'(r)].valid <= 1'b0;
                    ent_q[head_idx + rob_id_t'(r)].done  <= 1'b0;
                end
            end
            for (int p = 0; p < NUM_CDB; p++) begin
                if (cdb_val[p] && ent_q[cdb_robid[p]].valid) begin
                    ent_q[cdb_robid[p]].done       <= 1'b1;
                    ent_q[cdb_robid[p]].data       <= cdb_data[p];
                    ent_q[cdb_robid[p]].mispredict <= cdb_mispredict[p];
                end
            end
            if (alloc_ok) begin
                for (int s = 0; s < ISSUE_WIDTH_MAX; s++) begin
                    if (instr_val_is[s]) begin
                        ent_q[alloc_idx[s]] <= '{valid: 1'b1, done: 1'b0,
                            mispredict: 1'b0, branch: branch_is[s],
                            rd_we: rd_we_is[s], rd: rd_is[s], data: '0};
                    end
                end
            end
            clear_q <= flush;
            tag_q   <= flush ? flush_id : '0;
            head_q  <= head_q + ret_cnt;
            // the mispredicted entry is the last retiring one, so head+ret_cnt = robid+1
            if (flush) begin
                tail_q <= head_q + ret_cnt;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    ent_q[i].valid <= 1'b0;
                    ent_q[i].done  <= 1'b0;
                end
            end else if (alloc_ok) begin
                tail_q <= tail_q + alloc_cnt;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < ROB_MAX_RETIRE; r++) begin
            val_ret[r]    = ret_q[r].val;
            rd_ret[r]     = ret_q[r].rd;
            data_ret[r]   = ret_q[r].data;
            branch_ret[r] = ret_q[r].branch;
        end
    end
    assign branch_clear_id   = clear_q;
    assign mispredict_tag_id = tag_q;

    always @(posedge clk) begin
        if (rst) begin
            assert (!(rob_full && |instr_val_is))
            else $error("rob: allocation while full");
        end
    end
endmodule

// File: tb/tb_rob.sv
// Bench for rob: queue-based reference model, directed plan plus random traffic.
module tb_rob;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0]       instr_val_is, rd_we_is, branch_is;
    logic [1:0][4:0]  rd_is;
    logic [1:0]       cdb_val, cdb_mispredict;
    logic [1:0][4:0]  cdb_robid;
    logic [1:0][31:0] cdb_data;
    logic [4:0]       rob_is_ptr;
    logic             rob_full;
    logic [1:0]       val_ret, branch_ret;
    logic [1:0][4:0]  rd_ret;
    logic [1:0][31:0] data_ret;
    logic             branch_clear_id;
    logic [4:0]       mispredict_tag_id;

    always #5 clk = ~clk;

    rob dut (
        .clk(clk), .rst(rst),
        .instr_val_is(instr_val_is), .rd_is(rd_is),
        .rd_we_is(rd_we_is), .branch_is(branch_is),
        .rob_is_ptr(rob_is_ptr), .rob_full(rob_full),
        .cdb_val(cdb_val), .cdb_robid(cdb_robid),
        .cdb_data(cdb_data), .cdb_mispredict(cdb_mispredict),
        .val_ret(val_ret), .rd_ret(rd_ret), .data_ret(data_ret),
        .branch_ret(branch_ret), .branch_clear_id(branch_clear_id),
        .mispredict_tag_id(mispredict_tag_id)
    );

    typedef struct {
        int          id;
        int          rd;
        bit          we;
        bit          br;
        bit          done;
        bit          mis;
        logic [31:0] data;
    } ment_t;

    ment_t q[$];
    int    head = 0;
    int    checks = 0;
    int    passed = 0;

    logic [1:0]       e_val, e_br;
    logic [1:0][4:0]  e_rd;
    logic [1:0][31:0] e_data;
    logic             e_clr;
    logic [4:0]       e_tag;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic clr_in();
        instr_val_is = '0; rd_we_is = '0; branch_is = '0; rd_is = '0;
        cdb_val = '0; cdb_mispredict = '0; cdb_robid = '0; cdb_data = '0;
    endtask

    task automatic model_reset();
        q.delete();
        head = 0;
        e_val = '0; e_br = '0; e_rd = '0; e_data = '0;
        e_clr = 1'b0; e_tag = '0;
    endtask

    // What the registered outputs must be after the coming edge.
    task automatic model_step();
        int n = 0;
        bit fl = 0;
        int tag = 0;
        int tl;
        e_val = '0; e_br = '0; e_rd = '0; e_data = '0;
        for (int r = 0; r < 2; r++) begin
            if (fl || r >= q.size()) break;
            if (!q[r].done) break;
            e_val[r]  = 1'b1;
            e_rd[r]   = q[r].we ? 5'(q[r].rd) : 5'd0;
            e_data[r] = q[r].data;
            e_br[r]   = q[r].br;
            n++;
            if (q[r].mis) begin
                fl  = 1;
                tag = q[r].id;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (cdb_val[p]) begin
                foreach (q[i]) begin
                    if (q[i].id == int'(cdb_robid[p])) begin
                        q[i].done = 1;
                        q[i].data = cdb_data[p];
                        q[i].mis  = cdb_mispredict[p];
                    end
                end
            end
        end
        tl = head + q.size();
        for (int i = 0; i < n; i++) q.delete(0);
        head  = (head + n) % 64;
        e_clr = fl;
        e_tag = 5'(tag);
        if (fl) begin
            q.delete();
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (instr_val_is[s]) begin
                    ment_t m;
                    m.id = tl % 32;
                    m.rd = int'(rd_is[s]);
                    m.we = rd_we_is[s];
                    m.br = branch_is[s];
                    m.done = 0;
                    m.mis = 0;
                    m.data = '0;
                    q.push_back(m);
                    tl++;
                end
            end
        end
    endtask

    task automatic compare();
        chk("val_ret", 64'(val_ret), 64'(e_val));
        chk("rd_ret", 64'(rd_ret), 64'(e_rd));
        chk("data_ret", 64'(data_ret), 64'(e_data));
        chk("branch_ret", 64'(branch_ret), 64'(e_br));
        chk("branch_clear_id", 64'(branch_clear_id), 64'(e_clr));
        chk("mispredict_tag_id", 64'(mispredict_tag_id), 64'(e_tag));
        chk("rob_is_ptr", 64'(rob_is_ptr), 64'((head + q.size()) % 32));
        chk("rob_full", 64'(rob_full), 64'(q.size() > 30));
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare();
        clr_in();
    endtask

    task automatic alloc2(logic [1:0] v, logic [4:0] r0, logic [4:0] r1,
                          logic [1:0] br);
        instr_val_is = v;
        rd_is[0] = r0;
        rd_is[1] = r1;
        rd_we_is = 2'b11;
        branch_is = br;
        tick();
    endtask

    task automatic cdb2(logic [1:0] v, int id0, int id1, logic [1:0] mis);
        cdb_val = v;
        cdb_robid[0] = 5'(id0);
        cdb_robid[1] = 5'(id1);
        cdb_data[0] = $urandom;
        cdb_data[1] = $urandom;
        cdb_mispredict = mis;
        tick();
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_val_ret", 64'(val_ret), 64'd0);
        chk("rst_ptr", 64'(rob_is_ptr), 64'd0);
        chk("rst_full", 64'(rob_full), 64'd0);
        chk("rst_clear", 64'(branch_clear_id), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic rand_cycle(bit allow_cdb);
        int cand[$];
        int k;
        if (q.size() <= 30) instr_val_is = 2'($urandom_range(0, 3));
        rd_is = 10'($urandom);
        rd_we_is = 2'($urandom);
        branch_is = 2'($urandom);
        if (allow_cdb) begin
            foreach (q[i]) if (!q[i].done) cand.push_back(i);
            for (int p = 0; p < 2; p++) begin
                if (cand.size() > 0 && $urandom_range(0, 9) < 6) begin
                    k = int'($urandom_range(0, cand.size() - 1));
                    cdb_val[p] = 1'b1;
                    cdb_robid[p] = 5'(q[cand[k]].id);
                    cdb_data[p] = $urandom;
                    cdb_mispredict[p] = q[cand[k]].br &&
                                        ($urandom_range(0, 5) == 0);
                    cand.delete(k);
                end else if (p == 1 && q.size() < 32 &&
                             $urandom_range(0, 9) == 0) begin
                    cdb_val[1] = 1'b1;
                    cdb_robid[1] = 5'((head + q.size() +
                        int'($urandom_range(0, 31 - q.size()))) % 32);
                    cdb_data[1] = $urandom;
                end
            end
        end
        tick();
    endtask

    initial begin
        int w;
        clr_in();
        model_reset();
        repeat (2) @(negedge clk);
        chk("por_val_ret", 64'(val_ret), 64'd0);
        chk("por_ptr", 64'(rob_is_ptr), 64'd0);
        chk("por_full", 64'(rob_full), 64'd0);
        chk("por_data_ret", 64'(data_ret), 64'd0);
        rst = 1'b1;

        alloc2(2'b11, 5'd3, 5'd4, 2'b00);
        chk("lit_ptr2", 64'(rob_is_ptr), 64'd2);
        alloc2(2'b11, 5'd5, 5'd6, 2'b00);
        chk("lit_ptr4", 64'(rob_is_ptr), 64'd4);
        chk("lit_full0", 64'(rob_full), 64'd0);
        cdb2(2'b01, 1, 0, 2'b00);
        tick();
        chk("lit_noret", 64'(val_ret), 64'd0);
        cdb2(2'b01, 0, 0, 2'b00);
        tick();
        chk("lit_ret11", 64'(val_ret), 64'b11);
        chk("lit_rd43", 64'(rd_ret), 64'({5'd4, 5'd3}));

        repeat (14) alloc2(2'b11, 5'($urandom), 5'($urandom), 2'b00);
        alloc2(2'b01, 5'd9, 5'd0, 2'b00);
        chk("lit_full1", 64'(rob_full), 64'd1);
        chk("lit_wrap_ptr", 64'(rob_is_ptr), 64'd1);
        cdb2(2'b11, 2, 3, 2'b00);
        tick();
        chk("lit_ret2", 64'(val_ret), 64'b11);
        chk("lit_full_drop", 64'(rob_full), 64'd0);

        do_reset();
        alloc2(2'b11, 5'd1, 5'd2, 2'b00);
        alloc2(2'b11, 5'd3, 5'd4, 2'b00);
        alloc2(2'b11, 5'd5, 5'd6, 2'b10);
        alloc2(2'b11, 5'd7, 5'd8, 2'b00);
        cdb2(2'b11, 6, 0, 2'b00);
        cdb2(2'b11, 1, 2, 2'b00);
        cdb2(2'b11, 3, 4, 2'b00);
        cdb2(2'b01, 5, 0, 2'b01);
        w = 0;
        while (!branch_clear_id && w < 8) begin
            tick();
            w++;
        end
        chk("lit_clear", 64'(branch_clear_id), 64'd1);
        chk("lit_tag5", 64'(mispredict_tag_id), 64'd5);
        chk("lit_ret5", 64'(val_ret), 64'b01);
        chk("lit_ptr6", 64'(rob_is_ptr), 64'd6);
        tick();
        chk("lit_clear_pulse", 64'(branch_clear_id), 64'd0);

        alloc2(2'b10, 5'd0, 5'd7, 2'b00);
        cdb2(2'b01, 20, 0, 2'b00);
        chk("lit_ptr7", 64'(rob_is_ptr), 64'd7);
        cdb_data[0] = 32'hABCD_1234;
        cdb_val = 2'b01;
        cdb_robid[0] = 5'd6;
        tick();
        tick();
        chk("lit_ret_rd7", 64'(rd_ret[0]), 64'd7);
        chk("lit_ret_data", 64'(data_ret[0]), 64'hABCD_1234);

        repeat (3000) rand_cycle(1'b1);

        w = 0;
        while (q.size() < 10 && w < 40) begin
            rand_cycle(1'b0);
            w++;
        end
        chk("live_before_rst", 64'(q.size() >= 10), 64'd1);
        do_reset();
        repeat (4) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
